bias_add_sequencer: RTL and testbench

Sequences bias addition for one convolution layer's output stage. It sits between the N_adder_tree-lane adder-tree outputs and the activation/writeback path, and takes its bias constants from the layer's BIAS banks as one flattened bus. It walks the output-channel groups in order, selects the matching 16-lane bias word, and adds it to each accepted accumulator vector. Each result gets signed saturation and optional ReLU, and the output is registered with valid/ready flow control.

---
 rtl/bias_add_sequencer_pkg.sv | 11 +
 rtl/bias_sat_lane.sv | 16 +
 rtl/bias_add_sequencer.sv | 102 ++++++++++
 tb/tb_bias_add_sequencer.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/bias_add_sequencer_pkg.sv
// bias_add_sequencer_pkg: shared lane width, saturation limits, FSM encoding and lane-slice macro
`ifndef BIAS_ADD_SEQ_LANE
`define BIAS_ADD_SEQ_LANE(v, i, w) v[(i)*(w) +: (w)]
`endif

package bias_add_sequencer_pkg;
   localparam int W = 18;
   localparam logic [W-1:0] SAT_MAX = {1'b0, {(W-1){1'b1}}};
   localparam logic [W-1:0] SAT_MIN = {1'b1, {(W-1){1'b0}}};
   typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;
endpackage

// File: rtl/bias_sat_lane.sv
// bias_sat_lane: one-lane signed bias add with saturation and optional ReLU
module bias_sat_lane
(
   input  logic [bias_add_sequencer_pkg::W-1:0] data,
   input  logic [bias_add_sequencer_pkg::W-1:0] bias,
   input  logic                                 relu,
   output logic [bias_add_sequencer_pkg::W-1:0] res
);
   import bias_add_sequencer_pkg::*;
   logic [W:0]   sum;
   logic [W-1:0] sat;
   assign sum = {data[W-1], data} + {bias[W-1], bias};
   // the two top bits of the widened sum disagree only on overflow
   assign sat = (sum[W] == sum[W-1]) ? sum[W-1:0] : (sum[W] ? SAT_MIN : SAT_MAX);
   assign res = (relu && sat[W-1]) ? '0 : sat;
endmodule

// File: rtl/bias_add_sequencer.sv
// bias_add_sequencer: walks output-channel groups, adds the group's bias to each
// accepted accumulator vector and registers the saturated result with valid/ready.
module bias_add_sequencer #(
   parameter int N_adder_tree = 16,
   parameter int W = 18,
   parameter int N_GROUPS = 4,
   parameter int PIX_PER_GROUP = 729,
   localparam int GW = (N_GROUPS > 1) ? $clog2(N_GROUPS) : 1
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             start,
   input  logic                             relu_en,
   input  logic [N_GROUPS*N_adder_tree*W-1:0] bias_bus,
   input  logic [N_adder_tree*W-1:0]        in_data,
   input  logic                             in_valid,
   output logic                             in_ready,
   output logic [N_adder_tree*W-1:0]        out_data,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic [GW-1:0]                    out_grp,
   output logic                             out_last,
   output logic                             busy,
   output logic                             done
);
   import bias_add_sequencer_pkg::*;

   localparam int VW = N_adder_tree * W;
   localparam int PW = (PIX_PER_GROUP > 1) ? $clog2(PIX_PER_GROUP) : 1;
   localparam logic [PW-1:0] PIX_LAST = PW'(PIX_PER_GROUP - 1);
   localparam logic [GW-1:0] GRP_LAST = GW'(N_GROUPS - 1);

   state_t        state, nxt;
   logic [PW-1:0] pix_cnt;
   logic [GW-1:0] grp_cnt;
   logic          relu_q;
   logic          acc, pix_end, term;
   logic [VW-1:0] bias_sel, sum;

   assign in_ready = (state == RUN) && (!out_valid || out_ready);
   assign acc      = in_valid && in_ready;
   assign pix_end  = pix_cnt == PIX_LAST;
   assign term     = pix_end && (grp_cnt == GRP_LAST);
   assign bias_sel = bias_bus[grp_cnt*VW +: VW];
   assign busy     = state != IDLE;
   assign done     = state == DONE;

   for (genvar i = 0; i < N_adder_tree; i++) begin : g_lane
      bias_sat_lane u_lane (
         .data (`BIAS_ADD_SEQ_LANE(in_data, i, W)),
         .bias (`BIAS_ADD_SEQ_LANE(bias_sel, i, W)),
         .relu (relu_q),
         .res  (`BIAS_ADD_SEQ_LANE(sum, i, W))
      );
   end

   always_comb begin
      nxt = state;
      case (state)
         IDLE:    nxt = start ? RUN : IDLE;
         RUN:     nxt = (acc && term) ? FLUSH : RUN;
         FLUSH:   nxt = (out_valid && out_ready && out_last) ? DONE : FLUSH;
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         pix_cnt <= '0;
         grp_cnt <= '0;
         relu_q  <= 1'b0;
      end else begin
         state <= nxt;
         if (state == IDLE && start) begin
            pix_cnt <= '0;
            grp_cnt <= '0;
            relu_q  <= relu_en;
         end else if (acc) begin
            pix_cnt <= pix_end ? '0 : pix_cnt + 1'b1;
            if (pix_end) grp_cnt <= (grp_cnt == GRP_LAST) ? '0 : grp_cnt + 1'b1;
         end
      end
   end

   // a fresh accept reloads the register even while the old vector drains
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_grp   <= '0;
         out_last  <= 1'b0;
      end else if (acc) begin
         out_valid <= 1'b1;
         out_data  <= sum;
         out_grp   <= grp_cnt;
         out_last  <= term;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_bias_add_sequencer.sv
// tb_bias_add_sequencer: scoreboard bench for bias_add_sequencer with a 2-group, 3-pixel pass
module tb_bias_add_sequencer;
   localparam int N = 4, W = 18, NG = 2, PIX = 3, VW = N * W, NV = NG * PIX;

   logic clk = 0, rst_n = 0, start = 0, relu_en = 0, in_valid = 0, out_ready = 1;
   logic [NG*VW-1:0] bias_bus;
   logic [VW-1:0] in_data = '0, out_data;
   logic in_ready, out_valid, out_last, busy, done;
   logic [0:0] out_grp;

   typedef struct { logic [VW-1:0] data; int grp; logic last; } exp_t;
   exp_t sb[$];
   exp_t e;
   int n_tests = 0, n_fail = 0, mp = 0, mg = 0, out_idx = 0, done_cnt = 0, pass_id = 0;
   logic relu_m = 0, last_seen = 0;

   bias_add_sequencer #(.N_adder_tree(N), .W(W), .N_GROUPS(NG), .PIX_PER_GROUP(PIX)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .relu_en(relu_en), .bias_bus(bias_bus),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_grp(out_grp), .out_last(out_last), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic check(string tag, logic [VW-1:0] got, logic [VW-1:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [W-1:0] ref_lane(logic [W-1:0] a, logic [W-1:0] b, logic relu);
      int s;
      s = int'($signed(a)) + int'($signed(b));
      if (s > 2**(W-1) - 1) s = 2**(W-1) - 1;
      if (s < -(2**(W-1))) s = -(2**(W-1));
      if (relu && s < 0) s = 0;
      return s[W-1:0];
   endfunction

   function automatic logic [VW-1:0] ref_vec(logic [VW-1:0] d, int g, logic relu);
      logic [VW-1:0] r;
      for (int l = 0; l < N; l++) r[l*W +: W] = ref_lane(d[l*W +: W], bias_bus[(g*N+l)*W +: W], relu);
      return r;
   endfunction

   function automatic logic [VW-1:0] gen(int id, int n);
      logic [VW-1:0] v;
      v = {$urandom, $urandom, $urandom};
      if (id == 0 && n == 0) begin
         v[0*W +: W] = 18'h00100;
         v[1*W +: W] = 18'h1FFFF;
         v[2*W +: W] = 18'h20000;
      end
      if (id == 1 && n == 0) v[0*W +: W] = 18'h00010;
      return v;
   endfunction

   // monitor: predicts on input accept, compares on output handshake
   always @(negedge clk) begin
      if (!rst_n) begin
         mp = 0;
         mg = 0;
         last_seen = 0;
      end else begin
         if (last_seen) begin
            check("done_after_last", done, 1);
            last_seen = 0;
         end
         if (done) done_cnt++;
         if (start && !busy) begin
            mp = 0;
            mg = 0;
            relu_m = relu_en;
            out_idx = 0;
         end
         if (out_valid && out_ready) begin
            if (sb.size() == 0) check("sb_pending", sb.size(), 1);
            else begin
               e = sb.pop_front();
               check("out_data", out_data, e.data);
               check("out_grp", out_grp, e.grp);
               check("out_last", out_last, e.last);
               if (pass_id == 0 && out_idx == 0) begin
                  check("lane_bias_neg", out_data[0*W +: W], 18'h00000);
                  check("lane_sat_max", out_data[1*W +: W], 18'h1FFFF);
                  check("lane_sat_min", out_data[2*W +: W], 18'h20000);
               end
               if (pass_id == 1 && out_idx == 0) check("lane_relu", out_data[0*W +: W], 18'h00000);
               last_seen = out_last;
               out_idx++;
            end
         end
         if (in_valid && in_ready) begin
            sb.push_back('{ref_vec(in_data, mg, relu_m), mg, (mp == PIX-1 && mg == NG-1)});
            mp++;
            if (mp == PIX) begin
               mp = 0;
               mg++;
            end
         end
      end
   end

   task automatic do_pass(input int id, input logic relu, input int stall_at, input int restart_at, input int reset_at);
      int n = 0, cyc = 0, stall_left = 0, d0;
      logic stalled = 0, restarted = 0, acc, got;
      logic [VW-1:0] held = '0;
      pass_id = id;
      d0 = done_cnt;
      start = 1;
      relu_en = relu;
      @(posedge clk); #1;
      start = 0;
      relu_en = ~relu;
      in_data = gen(id, 0);
      while (n < NV && cyc < 100) begin
         cyc++;
         if (n == reset_at) begin
            rst_n = 0;
            #1;
            check("rst_out_valid", out_valid, 0);
            check("rst_out_data", out_data, 0);
            check("rst_busy", busy, 0);
            check("rst_in_ready", in_ready, 0);
            check("rst_out_last", out_last, 0);
            check("rst_done", done, 0);
            sb.delete();
            in_valid = 0;
            @(posedge clk); #1;
            rst_n = 1;
            return;
         end
         if (n == stall_at && !stalled) begin
            stalled = 1;
            stall_left = 4;
         end
         out_ready = (stall_left == 0);
         start = (n == restart_at && !restarted);
         if (start) restarted = 1;
         in_valid = 1;
         @(negedge clk);
         acc = in_valid && in_ready;
         if (stall_left > 0) begin
            if (stall_left == 4) held = out_data;
            else begin
               check("stall_in_ready", in_ready, 0);
               check("stall_hold", out_data, held);
            end
            stall_left--;
         end
         @(posedge clk); #1;
         if (acc) begin
            n++;
            in_data = gen(id, n);
         end
      end
      start = 0;
      in_valid = 0;
      out_ready = 1;
      check("vectors_accepted", n, NV);
      got = 0;
      for (int k = 0; k < 10 && !got; k++) begin
         @(negedge clk);
         got = done;
      end
      check("done_seen", got, 1);
      @(negedge clk);
      check("busy_after_done", busy, 0);
      check("done_once", done_cnt - d0, 1);
      check("sb_drained", sb.size(), 0);
      @(posedge clk); #1;
   endtask

   initial begin
      for (int g = 0; g < NG; g++) begin
         bias_bus[(g*N+0)*W +: W] = 18'h3FF00;
         bias_bus[(g*N+1)*W +: W] = 18'h00001;
         bias_bus[(g*N+2)*W +: W] = 18'h3FFFF;
         bias_bus[(g*N+3)*W +: W] = (g == 0) ? 18'h00005 : 18'h3FFF0;
      end
      in_valid = 1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_out_valid", out_valid, 0);
      check("reset_out_data", out_data, 0);
      check("reset_out_grp", out_grp, 0);
      check("reset_out_last", out_last, 0);
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      check("reset_in_ready", in_ready, 0);
      @(posedge clk); #1;
      rst_n = 1;
      @(negedge clk);
      check("idle_in_ready", in_ready, 0);
      check("idle_out_valid", out_valid, 0);
      check("idle_busy", busy, 0);
      @(posedge clk); #1;
      in_valid = 0;
      do_pass(0, 0, -1, -1, -1);
      do_pass(1, 1, -1, -1, -1);
      do_pass(2, 0, 2, 4, -1);
      do_pass(3, 0, -1, -1, 2);
      do_pass(4, 0, -1, -1, -1);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
